// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for data-memory interfaces: funct3 width codes,
// responder FSM states and access-size helper.
package data_memory_responder_pkg;

    localparam logic [2:0] WIDTH_B   = 3'b000;
    localparam logic [2:0] WIDTH_H   = 3'b001;
    localparam logic [2:0] WIDTH_W   = 3'b010;
    localparam logic [2:0] WIDTH_D   = 3'b011;
    localparam logic [2:0] WIDTH_BU  = 3'b100;
    localparam logic [2:0] WIDTH_HU  = 3'b101;
    localparam logic [2:0] WIDTH_WU  = 3'b110;
    localparam logic [2:0] WIDTH_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Unsigned variants share the size of their signed counterparts.
    function automatic logic [3:0] size_bytes(input logic [2:0] width);
        case (width[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_responder_load_store_aligner.sv
// Combinational RV64I lane handling: store byte-lane merge, load extract
// with sign/zero extension, and natural-alignment check.
module load_store_aligner
    import data_memory_responder_pkg::*;
(
    input  logic [2:0]  width_i,
    input  logic [2:0]  addr_lo_i,
    input  logic [63:0] old_word_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] store_word_o,
    output logic [63:0] load_data_o,
    output logic        misaligned_o
);

    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] base_mask;
    logic [63:0] lane_mask;

    assign shamt = {addr_lo_i, 3'b000};

    always_comb begin
        lane = old_word_i >> shamt;

        case (size_bytes(width_i))
            4'd1:    base_mask = 64'h0000_0000_0000_00FF;
            4'd2:    base_mask = 64'h0000_0000_0000_FFFF;
            4'd4:    base_mask = 64'h0000_0000_FFFF_FFFF;
            default: base_mask = '1;
        endcase
        lane_mask    = base_mask << shamt;
        store_word_o = (old_word_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);

        case (width_i)
            WIDTH_B:  load_data_o = {{56{lane[7]}},  lane[7:0]};
            WIDTH_H:  load_data_o = {{48{lane[15]}}, lane[15:0]};
            WIDTH_W:  load_data_o = {{32{lane[31]}}, lane[31:0]};
            WIDTH_D:  load_data_o = lane;
            WIDTH_BU: load_data_o = {56'd0, lane[7:0]};
            WIDTH_HU: load_data_o = {48'd0, lane[15:0]};
            WIDTH_WU: load_data_o = {32'd0, lane[31:0]};
            default:  load_data_o = '0;
        endcase

        case (width_i)
            WIDTH_H, WIDTH_HU: misaligned_o = addr_lo_i[0];
            WIDTH_W, WIDTH_WU: misaligned_o = (addr_lo_i[1:0] != 2'b00);
            WIDTH_D:           misaligned_o = (addr_lo_i != 3'b000);
            default:           misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: valid/ready load/store port onto a 64-bit RAM with
// programmable wait states and RV64I width semantics.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_width,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_rdata,
    output logic                  rsp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0]      WS_L    = CNT_W'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_L = (ADDR_WIDTH - 2)'(DEPTH_WORDS);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [2:0]            width_q, width_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [63:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    logic [63:0]           mem [0:DEPTH_WORDS-1];
    logic [ADDR_WIDTH-4:0] word_addr;
    logic [IDX_W-1:0]      word_idx;
    logic [63:0]           old_word;
    logic [63:0]           store_word;
    logic [63:0]           load_data;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  acc_err;
    logic                  mem_we;

    assign word_addr    = addr_q[ADDR_WIDTH-1:3];
    assign word_idx     = word_addr[IDX_W-1:0];
    assign out_of_range = ({1'b0, word_addr} >= DEPTH_L);
    assign old_word     = mem[word_idx];
    assign acc_err      = (width_q == WIDTH_ILL) || (write_q && width_q[2])
                          || misaligned || out_of_range;

    load_store_aligner u_aligner (
        .width_i      (width_q),
        .addr_lo_i    (addr_q[2:0]),
        .old_word_i   (old_word),
        .wdata_i      (wdata_q),
        .store_word_o (store_word),
        .load_data_o  (load_data),
        .misaligned_o (misaligned)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        width_d     = width_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    width_d = req_width;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q + CNT_W'(1) == WS_L) begin
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we      = write_q && !acc_err;
                rsp_valid_d = 1'b1;
                rsp_error_d = acc_err;
                rsp_rdata_d = (acc_err || write_q) ? '0 : load_data;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            width_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            width_q     <= width_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // RAM is deliberately outside the reset domain; only ACCESS commits stores.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= store_word;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the core's data-memory port: accepts load/store requests from the datapath through a valid/ready handshake.
- Performs the access on an internal 64-bit-wide RAM after a programmable number of wait states, then returns a response.
- Applies RV64I width semantics: LB/LH/LW/LD/LBU/LHU/LWU and SB/SH/SW/SD byte-lane merge.
- Flags misaligned, out-of-range and illegal-width accesses with an error.
- Replaces the single-cycle, always-ready memory model so the multicycle and pipelined datapaths can be exercised against wait states.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr.
- DEPTH_WORDS, 1024, number of 64-bit words in the RAM; valid byte addresses are 0 .. 8*DEPTH_WORDS-1.
- WAIT_STATES, 1, extra cycles between request acceptance and access; 0 is legal.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_width  in  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  64  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  64  load result, sign- or zero-extended; 0 for stores and errors.
- rsp_error  out  1  access faulted.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_error=0, wait counter 0. req_ready=1 as soon as rst is released. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write, width, addr and wdata. Go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: counter counts 1..WAIT_STATES; go to ACCESS after the last count. Request inputs are ignored.
- ACCESS (one cycle):
  - Error check on latched fields: width==111; store with width[2]=1; misalignment (H: addr[0]!=0, W/WU: addr[1:0]!=0, D: addr[2:0]!=0); out of range (addr>>3 >= DEPTH_WORDS).
  - Store without error: byte lanes addr[2:0] .. addr[2:0]+size-1 of word addr>>3 are written from wdata[8*size-1:0]; other lanes are unchanged.
  - Load without error: extract the lane and sign-extend (B/H/W) or zero-extend (BU/HU/WU/D) into rsp_rdata.
  - Error: no RAM write, rsp_rdata=0, rsp_error=1.
  - Next state RESP, with rsp_valid=1 registered.
- RESP: rsp_valid, rsp_rdata and rsp_error are held stable until rsp_ready=1. In that cycle's edge, clear rsp_valid, rsp_rdata and rsp_error, then go to IDLE.
- No back-to-back acceptance: a new request is accepted at the earliest one cycle after the response handshake.
- Latency: request accepted at edge N gives rsp_valid high after edge N+WAIT_STATES+1. With WAIT_STATES=1 and rsp_ready tied high, throughput is one transaction per 4 cycles.
- Simultaneous req_valid while in WAIT, ACCESS or RESP: ignored; req_ready=0.
- Reset mid-operation: the transaction is aborted. A store is committed only in ACCESS, so reset before ACCESS leaves the RAM untouched.
- Address wrap: not supported. Any address at or beyond 8*DEPTH_WORDS is an error, never aliased.

Decomposition:
- Shared package / header: funct3 width codes (WIDTH_B .. WIDTH_WU), FSM state encodings, size-in-bytes function. It is reused by the datapath and other memory interfaces.
- One natural sub-module: load_store_aligner (combinational).
  - Inputs: width, addr[2:0], old word, wdata.
  - Outputs: merged store word, extracted and extended load data, misaligned flag.

Test Plan:
- SD 0x0123456789ABCDEF to 0x10, then LD 0x10 -> rsp_rdata=0x0123456789ABCDEF, rsp_error=0, rsp_valid rises 2 cycles after acceptance (WAIT_STATES=1).
- SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFFFFFFFFFF80; LBU 0x13 -> 0x0000000000000080; LD 0x10 -> 0x0123456780ABCDEF.
- LW at 0x12 (misaligned) -> rsp_error=1, rsp_rdata=0. SH at 0x11 -> rsp_error=1 and a following LD 0x10 is unchanged.
- LD at 0x2000 with DEPTH_WORDS=1024 -> rsp_error=1. Width 111 load -> rsp_error=1. Width 100 store -> rsp_error=1, no write.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid/rsp_rdata stay stable, req_ready=0 throughout; rsp_ready=1 -> rsp_valid clears next edge and req_ready=1.
- Assert rst low during WAIT of SD 0xFFFF... to 0x20 -> outputs return to reset values immediately; after release, LD 0x20 returns the prior contents.
